// File: rtl/uart_programmer.sv
// UART boot loader: receives 8N1 bytes, assembles little-endian words and
// writes them into instruction then data memory, then reports ACK/NAK on tx.
module uart_programmer #(
  parameter int CLKS_PER_BIT = 87,
  parameter int IMEM_WORDS   = 16384,
  parameter int DMEM_WORDS   = 16384,
  parameter int TIMEOUT_CLKS = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_pg,
  input  logic        rx,
  output logic        tx,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        upg_err_o
);

  localparam int CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int TW   = $clog2(TIMEOUT_CLKS + 1);
  localparam int HALF = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(TIMEOUT_CLKS - 1);
  localparam logic [15:0]   IMEM_W  = 16'(IMEM_WORDS);
  localparam logic [15:0]   TOTAL_W = 16'(IMEM_WORDS + DMEM_WORDS);
  localparam logic [7:0]    ACK_BYTE = 8'h4B;
  localparam logic [7:0]    NAK_BYTE = 8'h4E;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ACK, ST_NAK} state_t;

  logic rx_s1_q, rx_s2_q, rx_s3_q;
  logic st_s1_q, st_s2_q, st_s3_q;
  logic rx_fall, start_rise;

  rx_state_t   rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_en, byte_valid, frame_err;

  state_t      state_q, state_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        wen_q, wen_d;
  logic [14:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [15:0] w_q, w_d;
  logic [1:0]  bi_q, bi_d;
  logic [23:0] asm_q, asm_d;
  logic [TW-1:0] to_q, to_d;
  logic        tx_q, tx_d;
  logic [9:0]  tx_sh_q, tx_sh_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic        abort;
  logic [15:0] woff;
  logic        unused_hi;

  assign rx_fall    = rx_s3_q & ~rx_s2_q;
  assign start_rise = st_s2_q & ~st_s3_q;
  assign rx_en      = (state_q == ST_LOAD);
  assign unused_hi  = ^woff[15:14];

  assign tx         = tx_q;
  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = done_q;
  assign upg_err_o  = err_q;

  // Two-stage synchronisers plus one extra stage for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {rx_s1_q, rx_s2_q, rx_s3_q} <= 3'b111;
      {st_s1_q, st_s2_q, st_s3_q} <= 3'b000;
    end else begin
      {rx_s1_q, rx_s2_q, rx_s3_q} <= {rx, rx_s1_q, rx_s2_q};
      {st_s1_q, st_s2_q, st_s3_q} <= {start_pg, st_s1_q, st_s2_q};
    end
  end

  // Receiver: start-bit recheck at half bit, then mid-bit sampling
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_M1) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_M1) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          byte_valid = rx_s2_q;
          frame_err  = ~rx_s2_q;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (!rx_en) begin
      rx_state_d = RX_IDLE;
      rx_cnt_d   = '0;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
    end
  end

  // Receiver state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  // Loader FSM: word assembly, memory writes, timeout and status byte
  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    err_d    = err_q;
    wen_d    = 1'b0;
    adr_d    = adr_q;
    dat_d    = dat_q;
    w_d      = w_q;
    bi_d     = bi_q;
    asm_d    = asm_q;
    to_d     = to_q;
    tx_d     = 1'b1;
    tx_sh_d  = tx_sh_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    abort    = 1'b0;
    woff     = (w_q < IMEM_W) ? w_q : (w_q - IMEM_W);
    unique case (state_q)
      ST_IDLE: begin
        done_d = 1'b1;
        if (start_rise) begin
          state_d = ST_LOAD;
          done_d  = 1'b0;
          err_d   = 1'b0;
          bi_d    = '0;
          w_d     = '0;
          to_d    = '0;
        end
      end
      ST_LOAD: begin
        if (wen_q && w_q == TOTAL_W) begin
          state_d  = ST_ACK;
          done_d   = 1'b1;
          tx_sh_d  = {1'b1, ACK_BYTE, 1'b0};
          tx_cnt_d = '0;
          tx_bit_d = '0;
        end else if (frame_err) begin
          abort = 1'b1;
        end else if (byte_valid) begin
          to_d  = '0;
          bi_d  = bi_q + 2'd1;
          asm_d = {rx_sh_q, asm_q[23:8]};
          if (bi_q == 2'd3) begin
            wen_d = 1'b1;
            dat_d = {rx_sh_q, asm_q};
            adr_d = {~(w_q < IMEM_W), woff[13:0]};
            w_d   = w_q + 16'd1;
          end
        end else if (to_q == TO_M1) begin
          abort = 1'b1;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      ST_ACK, ST_NAK: begin
        tx_d     = tx_sh_q[0];
        tx_cnt_d = tx_cnt_q + CW'(1);
        if (tx_cnt_q == BIT_M1) begin
          tx_cnt_d = '0;
          tx_sh_d  = {1'b1, tx_sh_q[9:1]};
          tx_bit_d = tx_bit_q + 4'd1;
          if (tx_bit_q == 4'd9) begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d  = ST_NAK;
      err_d    = 1'b1;
      done_d   = 1'b1;
      tx_sh_d  = {1'b1, NAK_BYTE, 1'b0};
      tx_cnt_d = '0;
      tx_bit_d = '0;
    end
  end

  // Loader state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b1;
      err_q    <= 1'b0;
      wen_q    <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      w_q      <= '0;
      bi_q     <= '0;
      asm_q    <= '0;
      to_q     <= '0;
      tx_q     <= 1'b1;
      tx_sh_q  <= '1;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      err_q    <= err_d;
      wen_q    <= wen_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      w_q      <= w_d;
      bi_q     <= bi_d;
      asm_q    <= asm_d;
      to_q     <= to_d;
      tx_q     <= tx_d;
      tx_sh_q  <= tx_sh_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
    end
  end

endmodule
